// File: rtl/pio_v2_pkg.sv
// ============================================================================
// Module : pio_v2_pkg
// Brief  : Register map, AXI responses, FSM encodings and strobe helper for pio_v2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pio_v2_pkg;

  // Word index of each register (byte offset >> 2, decoded from addr[5:2])
  localparam logic [3:0] ADDR_ODATA    = 4'h0;
  localparam logic [3:0] ADDR_OENABLE  = 4'h1;
  localparam logic [3:0] ADDR_IDATA    = 4'h2;
  localparam logic [3:0] ADDR_OSET     = 4'h3;
  localparam logic [3:0] ADDR_OCLR     = 4'h4;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'h5;
  localparam logic [3:0] ADDR_IRQ_TYPE = 4'h6;
  localparam logic [3:0] ADDR_IRQ_PEND = 4'h7;
  localparam logic [3:0] ADDR_IRQ_POL  = 4'h8;
  localparam logic [3:0] ADDR_IRQ_ANY  = 4'h9;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] W_I = 3'b001;
  localparam logic [2:0] W_A = 3'b010;
  localparam logic [2:0] W_D = 3'b100;

  localparam logic [1:0] R_I = 2'b01;
  localparam logic [1:0] R_D = 2'b10;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old;
    for (int k = 0; k < 4; k++) begin
      if (wstrb[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pio_v2_sync.sv
// ============================================================================
// Module : pio_v2_sync
// Brief  : Multi-stage flop synchronizer for asynchronous pin inputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pio_v2_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_din;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dout = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pio_v2.sv
// ============================================================================
// Module : pio_v2
// Brief  : AXI4-Lite parallel I/O with set/clear, synchronized inputs and IRQs.
//          Optional both-edge/polarity interrupts via PIO_V2_BOTH_EDGE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pio_v2
  import pio_v2_pkg::*;
#(
  parameter int addrWidth  = 32,
  parameter int dataWidth  = 32,
  parameter int pioWidth   = 16,
  parameter int syncStages = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   t_ctrl_awvalid,
  output logic                   t_ctrl_awready,
  input  logic [addrWidth-1:0]   t_ctrl_awaddr,
  input  logic [2:0]             t_ctrl_awprot,
  input  logic                   t_ctrl_wvalid,
  output logic                   t_ctrl_wready,
  input  logic [dataWidth-1:0]   t_ctrl_wdata,
  input  logic [dataWidth/8-1:0] t_ctrl_wstrb,
  output logic                   t_ctrl_bvalid,
  input  logic                   t_ctrl_bready,
  output logic [1:0]             t_ctrl_bresp,
  input  logic                   t_ctrl_arvalid,
  output logic                   t_ctrl_arready,
  input  logic [addrWidth-1:0]   t_ctrl_araddr,
  input  logic [2:0]             t_ctrl_arprot,
  output logic                   t_ctrl_rvalid,
  input  logic                   t_ctrl_rready,
  output logic [dataWidth-1:0]   t_ctrl_rdata,
  output logic [1:0]             t_ctrl_rresp,
  output logic [pioWidth-1:0]    odata,
  output logic [pioWidth-1:0]    oenable,
  input  logic [pioWidth-1:0]    idata,
  output logic                   irq
);

  logic [2:0]           r_wstate, w_wstate_nxt;
  logic [1:0]           r_rstate, w_rstate_nxt;
  logic [3:0]           r_awidx, w_widx;
  logic [1:0]           r_bresp, w_bresp;
  logic [dataWidth-1:0] r_rdata, w_rdata;
  logic [1:0]           r_rresp, w_rresp;
  logic                 w_whs, w_arhs, r_irq;

  logic [31:0]         w_wbits32, w_lanes32;
  logic [pioWidth-1:0] w_wbits, w_lanes;
  logic [pioWidth-1:0] r_odata, r_oen, r_ien, r_itype, r_pend, r_prev;
  logic [pioWidth-1:0] w_sync, w_trig, w_pend_set, w_pend_clr, w_pend_nxt, w_ien_nxt;
`ifdef PIO_V2_BOTH_EDGE_EN
  logic [pioWidth-1:0] r_ipol, r_iany;
`endif

  logic w_unused;
  assign w_unused = ^{t_ctrl_awprot, t_ctrl_arprot, t_ctrl_awaddr[addrWidth-1:6],
                      t_ctrl_awaddr[1:0], t_ctrl_araddr[addrWidth-1:6],
                      t_ctrl_araddr[1:0], w_wbits32, w_lanes32};

  pio_v2_sync #(.WIDTH(pioWidth), .STAGES(syncStages)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_din   (idata),
    .o_dout  (w_sync)
  );

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_wstate <= W_I;
    else          r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_I:     if (t_ctrl_awvalid) w_wstate_nxt = t_ctrl_wvalid ? W_D : W_A;
      W_A:     if (t_ctrl_wvalid)  w_wstate_nxt = W_D;
      W_D:     if (t_ctrl_bready)  w_wstate_nxt = W_I;
      default: w_wstate_nxt = W_I;
    endcase
  end

  always_comb begin
    t_ctrl_awready = (r_wstate == W_I);
    t_ctrl_wready  = (r_wstate == W_A) || ((r_wstate == W_I) && t_ctrl_awvalid);
    t_ctrl_bvalid  = (r_wstate == W_D);
  end

  assign w_whs  = t_ctrl_wvalid & t_ctrl_wready;
  assign w_widx = (r_wstate == W_A) ? r_awidx : t_ctrl_awaddr[5:2];

  assign w_wbits32 = apply_wstrb('0, t_ctrl_wdata, t_ctrl_wstrb);
  assign w_lanes32 = apply_wstrb('0, '1, t_ctrl_wstrb);
  assign w_wbits   = w_wbits32[pioWidth-1:0];
  assign w_lanes   = w_lanes32[pioWidth-1:0];

  always_comb begin
    w_bresp = RESP_OKAY;
    case (w_widx)
      ADDR_ODATA, ADDR_OENABLE, ADDR_IDATA, ADDR_OSET, ADDR_OCLR,
      ADDR_IRQ_EN, ADDR_IRQ_TYPE, ADDR_IRQ_PEND: w_bresp = RESP_OKAY;
`ifdef PIO_V2_BOTH_EDGE_EN
      ADDR_IRQ_POL, ADDR_IRQ_ANY: w_bresp = RESP_OKAY;
`endif
      default: w_bresp = RESP_SLVERR;
    endcase
  end

  // ---------------- interrupt sources ----------------
`ifdef PIO_V2_BOTH_EDGE_EN
  assign w_trig = (r_itype &  r_iany & (w_sync ^ r_prev))
                | (r_itype & ~r_iany & (w_sync ^ r_ipol) & ~(r_prev ^ r_ipol))
                | (~r_itype & (w_sync ^ r_ipol));
`else
  assign w_trig = (r_itype & w_sync & ~r_prev) | (~r_itype & w_sync);
`endif

  assign w_pend_set = r_ien & w_trig;
  assign w_pend_clr = (w_whs && w_widx == ADDR_IRQ_PEND) ? w_wbits : '0;
  // A new event in the same cycle as its W1C keeps the bit pending.
  assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_pend_set;
  assign w_ien_nxt  = (w_whs && w_widx == ADDR_IRQ_EN) ? ((r_ien & ~w_lanes) | w_wbits) : r_ien;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_awidx <= '0;
      r_bresp <= RESP_OKAY;
      r_odata <= '0;
      r_oen   <= '0;
      r_ien   <= '0;
      r_itype <= '0;
      r_pend  <= '0;
      r_prev  <= '0;
      r_irq   <= 1'b0;
`ifdef PIO_V2_BOTH_EDGE_EN
      r_ipol  <= '0;
      r_iany  <= '0;
`endif
    end else begin
      if (r_wstate == W_I && t_ctrl_awvalid) r_awidx <= t_ctrl_awaddr[5:2];
      if (w_whs) begin
        r_bresp <= w_bresp;
        case (w_widx)
          ADDR_ODATA:    r_odata <= (r_odata & ~w_lanes) | w_wbits;
          ADDR_OENABLE:  r_oen   <= (r_oen   & ~w_lanes) | w_wbits;
          ADDR_OSET:     r_odata <= r_odata | w_wbits;
          ADDR_OCLR:     r_odata <= r_odata & ~w_wbits;
          ADDR_IRQ_TYPE: r_itype <= (r_itype & ~w_lanes) | w_wbits;
`ifdef PIO_V2_BOTH_EDGE_EN
          ADDR_IRQ_POL:  r_ipol  <= (r_ipol  & ~w_lanes) | w_wbits;
          ADDR_IRQ_ANY:  r_iany  <= (r_iany  & ~w_lanes) | w_wbits;
`endif
          default: ;
        endcase
      end
      r_ien  <= w_ien_nxt;
      r_pend <= w_pend_nxt;
      r_prev <= w_sync;
      r_irq  <= |(w_pend_nxt & w_ien_nxt);
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rstate <= R_I;
    else          r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_I:     if (t_ctrl_arvalid) w_rstate_nxt = R_D;
      R_D:     if (t_ctrl_rready)  w_rstate_nxt = R_I;
      default: w_rstate_nxt = R_I;
    endcase
  end

  always_comb begin
    t_ctrl_arready = (r_rstate == R_I);
    t_ctrl_rvalid  = (r_rstate == R_D);
  end

  assign w_arhs = t_ctrl_arvalid & t_ctrl_arready;

  always_comb begin
    w_rdata = '0;
    w_rresp = RESP_OKAY;
    case (t_ctrl_araddr[5:2])
      ADDR_ODATA:            w_rdata = dataWidth'(r_odata);
      ADDR_OENABLE:          w_rdata = dataWidth'(r_oen);
      ADDR_IDATA:            w_rdata = dataWidth'(w_sync);
      ADDR_OSET, ADDR_OCLR:  w_rdata = '0;
      ADDR_IRQ_EN:           w_rdata = dataWidth'(r_ien);
      ADDR_IRQ_TYPE:         w_rdata = dataWidth'(r_itype);
      ADDR_IRQ_PEND:         w_rdata = dataWidth'(r_pend);
`ifdef PIO_V2_BOTH_EDGE_EN
      ADDR_IRQ_POL:          w_rdata = dataWidth'(r_ipol);
      ADDR_IRQ_ANY:          w_rdata = dataWidth'(r_iany);
`endif
      default:               w_rresp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_arhs) begin
      r_rdata <= w_rdata;
      r_rresp <= w_rresp;
    end
  end

  assign t_ctrl_bresp = r_bresp;
  assign t_ctrl_rdata = r_rdata;
  assign t_ctrl_rresp = r_rresp;
  assign odata        = r_odata;
  assign oenable      = r_oen;
  assign irq          = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_pio_v2.sv
// ============================================================================
// Module : tb_pio_v2
// Brief  : Scoreboard-based self-checking bench for pio_v2 (default build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pio_v2;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [15:0] odata, oenable, idata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] exp_r [$];
  logic [1:0]  exp_b [$];

  pio_v2 #(.addrWidth(32), .dataWidth(32), .pioWidth(16), .syncStages(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .t_ctrl_awvalid(awvalid), .t_ctrl_awready(awready), .t_ctrl_awaddr(awaddr),
    .t_ctrl_awprot(3'b000),
    .t_ctrl_wvalid(wvalid), .t_ctrl_wready(wready), .t_ctrl_wdata(wdata),
    .t_ctrl_wstrb(wstrb),
    .t_ctrl_bvalid(bvalid), .t_ctrl_bready(bready), .t_ctrl_bresp(bresp),
    .t_ctrl_arvalid(arvalid), .t_ctrl_arready(arready), .t_ctrl_araddr(araddr),
    .t_ctrl_arprot(3'b000),
    .t_ctrl_rvalid(rvalid), .t_ctrl_rready(rready), .t_ctrl_rdata(rdata),
    .t_ctrl_rresp(rresp),
    .odata(odata), .oenable(oenable), .idata(idata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_hi(input string tag, ref logic sig);
    int t;
    t = 0;
    while (sig !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    logic [1:0] e;
    exp_b.push_back(er);
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    wait_hi({tag, "_aw"}, awready);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_hi({tag, "_b"}, bvalid);
    e = exp_b.pop_front();
    check({tag, "_bresp"}, 32'(bresp), 32'(e));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [31:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
    logic [33:0] e;
    exp_r.push_back({er, ed});
    @(negedge clk);
    arvalid = 1'b1; araddr = a;
    wait_hi({tag, "_ar"}, arready);
    @(negedge clk);
    arvalid = 1'b0;
    wait_hi({tag, "_r"}, rvalid);
    e = exp_r.pop_front();
    check({tag, "_rdata"}, rdata, e[31:0]);
    check({tag, "_rresp"}, 32'(rresp), 32'(e[33:32]));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; idata = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_awready", 32'(awready), 1);
    check("rst_arready", 32'(arready), 1);
    check("rst_bvalid",  32'(bvalid),  0);
    check("rst_rvalid",  32'(rvalid),  0);
    check("rst_odata",   32'(odata),   0);
    check("rst_oenable", 32'(oenable), 0);
    check("rst_irq",     32'(irq),     0);

    // byte-strobed write
    axi_write("wr_strb", 32'h00, 32'h0000A5A5, 4'b0001, 2'b00);
    check("odata_strb", 32'(odata), 32'h00A5);
    axi_read("rd_odata", 32'h00, 32'h000000A5, 2'b00);

    // atomic set / clear
    axi_write("wr_f0", 32'h00, 32'h000000F0, 4'hF, 2'b00);
    axi_write("wr_oset", 32'h0C, 32'h0000000F, 4'hF, 2'b00);
    check("odata_oset", 32'(odata), 32'h00FF);
    axi_write("wr_oclr", 32'h10, 32'h00000030, 4'hF, 2'b00);
    check("odata_oclr", 32'(odata), 32'h00CF);
    axi_read("rd_oset", 32'h0C, 32'h0, 2'b00);
    axi_read("rd_oclr", 32'h10, 32'h0, 2'b00);

    // bits above pioWidth ignored
    axi_write("wr_oen", 32'h04, 32'hFFFFFFFF, 4'hF, 2'b00);
    axi_read("rd_oen", 32'h04, 32'h0000FFFF, 2'b00);
    check("oenable", 32'(oenable), 32'hFFFF);

    // AW held three cycles ahead of W, then slow bready
    exp_b.push_back(2'b00);
    @(negedge clk);
    check("wready_pre_aw", 32'(wready), 0);
    awvalid = 1'b1; awaddr = 32'h00; wvalid = 1'b0; wdata = 32'h00001234; wstrb = 4'hF;
    #1;
    check("wready_with_aw", 32'(wready), 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("awready_wa", 32'(awready), 0);
      check("wready_wa", 32'(wready), 1);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("bvalid_rise", 32'(bvalid), 1);
    check("odata_slow", 32'(odata), 32'h1234);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(bvalid), 1);
    end
    check("slow_bresp", 32'(bresp), 32'(exp_b.pop_front()));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", 32'(bvalid), 0);

    // synchronized input readback
    idata = 16'h5A5A;
    repeat (S + 1) @(negedge clk);
    axi_read("rd_idata", 32'h08, 32'h00005A5A, 2'b00);
    idata = 16'h0000;
    repeat (S + 1) @(negedge clk);

    // rising-edge interrupt latency
    axi_write("wr_itype1", 32'h18, 32'h1, 4'hF, 2'b00);
    axi_write("wr_ien1", 32'h14, 32'h1, 4'hF, 2'b00);
    idata[0] = 1'b1;
    for (int k = 1; k <= S + 2; k++) begin
      @(negedge clk);
      check($sformatf("irq_lat%0d", k), 32'(irq), (k >= S + 1) ? 32'd1 : 32'd0);
    end
    axi_write("w1c_edge", 32'h1C, 32'h1, 4'hF, 2'b00);
    check("irq_after_w1c", 32'(irq), 0);
    repeat (3) @(negedge clk);
    check("irq_pin_high", 32'(irq), 0);
    axi_read("rd_pend_edge", 32'h1C, 32'h0, 2'b00);
    idata = 16'h0000;
    repeat (S + 1) @(negedge clk);

    // level interrupt re-asserts while pin stays high
    axi_write("wr_ien8", 32'h14, 32'h8, 4'hF, 2'b00);
    axi_write("wr_itype0", 32'h18, 32'h0, 4'hF, 2'b00);
    idata[3] = 1'b1;
    repeat (S + 2) @(negedge clk);
    check("irq_level", 32'(irq), 1);
    axi_read("rd_pend_lvl", 32'h1C, 32'h8, 2'b00);
    axi_write("w1c_lvl", 32'h1C, 32'h8, 4'hF, 2'b00);
    axi_read("rd_pend_reset", 32'h1C, 32'h8, 2'b00);
    axi_write("wr_ien0", 32'h14, 32'h0, 4'hF, 2'b00);
    check("irq_masked", 32'(irq), 0);
    axi_read("rd_pend_kept", 32'h1C, 32'h8, 2'b00);
    idata = 16'h0000;

    // unmapped offsets
    axi_read("rd_3c", 32'h3C, 32'h0, 2'b10);
    axi_read("rd_20", 32'h20, 32'h0, 2'b10);
    axi_write("wr_3c", 32'h3C, 32'hFFFFFFFF, 4'hF, 2'b10);
    axi_read("rd_odata_kept", 32'h00, 32'h00001234, 2'b00);

    // reset while address is held
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h00; wvalid = 1'b0;
    @(negedge clk);
    check("in_wa", 32'(awready), 0);
    reset_n = 1'b0;
    awvalid = 1'b0;
    #1;
    check("rst_mid_awready", 32'(awready), 1);
    check("rst_mid_bvalid", 32'(bvalid), 0);
    check("rst_mid_odata", 32'(odata), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_bvalid", 32'(bvalid), 0);
    axi_read("rd_after_rst", 32'h00, 32'h0, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pio_v2.md
Name: pio_v2

Overview:
Second-generation parallel I/O block with an AXI4-Lite register slave and a configurable pin count.
- Adds byte-strobe writes and atomic set/clear of output bits.
- Adds an input synchronizer and per-pin interrupt logic (level or rising edge, sticky pending, W1C), combined into one IRQ line.
- Sits on the peripheral AXI4-Lite fabric and drives the pad ring directly.

Parameters:
addrWidth, 32, AXI address width
dataWidth, 32, AXI data width; must be 32
pioWidth, 16, number of pins; 1..dataWidth
syncStages, 2, input synchronizer depth; >=2

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
t_ctrl_awvalid/awready  in/out  1  AW handshake
t_ctrl_awaddr  in  addrWidth  write address; bits [5:2] decoded
t_ctrl_awprot  in  3  ignored
t_ctrl_wvalid/wready  in/out  1  W handshake
t_ctrl_wdata  in  dataWidth  write data
t_ctrl_wstrb  in  dataWidth/8  byte strobes
t_ctrl_bvalid/bready  out/in  1  B handshake
t_ctrl_bresp  out  2  OKAY=00, SLVERR=10
t_ctrl_arvalid/arready  in/out  1  AR handshake
t_ctrl_araddr  in  addrWidth  read address; bits [5:2] decoded
t_ctrl_arprot  in  3  ignored
t_ctrl_rvalid/rready  out/in  1  R handshake
t_ctrl_rdata  out  dataWidth  read data, zero-extended above pioWidth
t_ctrl_rresp  out  2  OKAY/SLVERR
odata  out  pioWidth  pin output values
oenable  out  pioWidth  pin output enables
idata  in  pioWidth  asynchronous pin inputs
irq  out  1  combined interrupt, level, active high

Behaviour:
- Reset values: all registers 0; odata=0, oenable=0, irq=0; valid/ready outputs reflect the idle state (awready=1, arready=1, bvalid=0, rvalid=0); synchronizer flops 0.
- Register map (byte offset). Rows marked W1 are write-only and read 0.
  - 0x00 ODATA rw
  - 0x04 OENABLE rw
  - 0x08 IDATA ro (synchronized)
  - 0x0C OSET W1 (odata |= wdata)
  - 0x10 OCLR W1 (odata &= ~wdata)
  - 0x14 IRQ_EN rw
  - 0x18 IRQ_TYPE rw (0=level-high, 1=rising edge)
  - 0x1C IRQ_PEND rw1c
  - Other offsets: reads return 0 with SLVERR; writes have no effect, bresp=SLVERR.
- Write FSM, one-hot, states W_I (idle), W_A (address held), W_D (response).
  - awready = W_I.
  - wready = W_A, or W_I with awvalid high (W is never accepted before AW).
  - W_I→W_D when AW and W both handshake in the same cycle.
  - W_I→W_A on AW handshake alone.
  - W_A→W_D on W handshake.
  - W_D→W_I on bvalid&bready.
  - The register update occurs in the W handshake cycle; bvalid rises the next cycle and holds until bready.
- Strobes: byte lane k updates bits [8k+7:8k] only when wstrb[k]=1; applies to every writable register, including OSET, OCLR and W1C.
- Read FSM, states R_I and R_D.
  - arready = R_I.
  - Read data and response are registered on the AR handshake.
  - rvalid is high in R_D and rdata is stable until rready.
  - Read latency is 1 cycle.
  - Read and write paths are independent; a same-cycle read of a register being written returns the old value.
- Input path: idata passes through syncStages flops to give sync_in, which is the IDATA value. An edge register holds sync_in delayed by one cycle.
- Pending bit i is set when IRQ_EN[i] and:
  - level: sync_in[i]=1;
  - edge: sync_in[i] & ~prev[i].
- Pending bits are sticky until W1C. When a set and a W1C hit the same bit in the same cycle, set wins. Clearing a level source while the pin is still high re-sets the bit on the next cycle.
- irq = |(IRQ_PEND & IRQ_EN), driven from registers only (no glitches). Clearing IRQ_EN masks irq but keeps pending bits.
- Latency: pin rise to irq = syncStages+1 cycles (edge and level alike).
- Bits at or above pioWidth: write-ignored, read 0.
- Reset asserted mid-transaction aborts it: FSMs return to idle and no response is issued.

Optional Feature:
PIO_V2_BOTH_EDGE_EN.
- With it defined:
  - New register IRQ_POL rw at 0x20, reset 0.
  - Level type triggers on sync_in == ~IRQ_POL.
  - Edge type with POL=0 triggers on rising edges; with POL=1 it triggers on falling edges.
  - An additional register IRQ_ANY rw at 0x24 triggers on either edge wherever IRQ_TYPE=1 and the IRQ_ANY bit is set.
- Without it: offsets 0x20 and 0x24 are unmapped (SLVERR), and behaviour is as above.

Decomposition:
- Package pio_v2_pkg holds:
  - register offset localparams;
  - RESP_OKAY and RESP_SLVERR;
  - one-hot state encodings W_I/W_A/W_D and R_I/R_D;
  - function apply_wstrb(old, wdata, wstrb).
- One sub-module, pio_v2_sync, a pioWidth-wide, syncStages-deep synchronizer with async reset, instantiated once.

Test Plan:
- Write 0x0000A5A5 to ODATA with wstrb=0001, then read ODATA → odata=0x00A5, rdata=0x000000A5, rresp=OKAY.
- From odata=0x00F0: write OSET 0x000F, then OCLR 0x0030 → odata=0x00CF; reads of OSET/OCLR return 0.
- Hold AW valid for 3 cycles with wvalid low, then assert W → wready only from the cycle AW is accepted onwards; bvalid 1 cycle after the W handshake, held through 4 cycles of bready=0.
- Set IRQ_EN=0x0001, IRQ_TYPE=1, pulse idata[0] high → irq rises exactly syncStages+1 cycles after the edge. W1C IRQ_PEND=1 → irq=0 while the pin stays high.
- Level mode, idata[3]=1, IRQ_EN=0x0008 → W1C of bit 3 leaves PEND[3]=1 one cycle later. Clearing IRQ_EN → irq=0 and PEND still reads 0x0008.
- Read offset 0x3C → rdata=0, rresp=SLVERR. Write to 0x3C → bresp=SLVERR and no register changes. Assert reset_n low during W_A → awready=1, bvalid=0, odata=0.
